dfr_reservoir_core: RTL

//  Parametrised delay-feedback reservoir: NUM_VIRTUAL_NODES-deep delay line of NODE_DATA_WIDTH nodes.
//  Per accepted input: sum = din + (oldest node scaled, >>eta), saturated; sent over req/ack to an external

---
 rtl/dfr_pkg.sv | 24 ++
 rtl/reservoir_delay_line.sv | 43 ++++
 rtl/dfr_reservoir_core.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dfr_pkg.sv
// Shared types and helpers for the delay-feedback reservoir core.
package dfr_pkg;

    localparam int ETA_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        NL_WAIT,
        SHIFT
    } dfr_state_t;

    // Unsigned add clamped to 2^w-1; operands must fit in 64 bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/reservoir_delay_line.sv
// Virtual-node storage: shift-in at node 0, random-access load, combinational readback.
module reservoir_delay_line #(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int NODE_DATA_WIDTH   = 12,
    parameter int SEL_W             = $clog2(NUM_VIRTUAL_NODES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       shift_en,
    input  logic [NODE_DATA_WIDTH-1:0] shift_din,
    input  logic                       load_en,
    input  logic [SEL_W-1:0]           load_sel,
    input  logic [NODE_DATA_WIDTH-1:0] load_din,
    input  logic [SEL_W-1:0]           rd_sel,
    output logic [NODE_DATA_WIDTH-1:0] rd_data,
    output logic [NODE_DATA_WIDTH-1:0] last
);

    logic [NUM_VIRTUAL_NODES-1:0][NODE_DATA_WIDTH-1:0] nodes;

    // Out-of-range load indices match no node and fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nodes <= '0;
        end else if (shift_en) begin
            nodes <= {nodes[NUM_VIRTUAL_NODES-2:0], shift_din};
        end else if (load_en) begin
            for (int k = 0; k < NUM_VIRTUAL_NODES; k++) begin
                if (load_sel == SEL_W'(k)) nodes[k] <= load_din;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_VIRTUAL_NODES; k++) begin
            if (rd_sel == SEL_W'(k)) rd_data = nodes[k];
        end
    end

    assign last = nodes[NUM_VIRTUAL_NODES-1];

endmodule

// File: rtl/dfr_reservoir_core.sv
// Delay-feedback reservoir: input + scaled oldest node -> external nonlinearity -> node 0.
// Define DFR_NL_TIMEOUT_EN to bound the nonlinearity wait by NL_TIMEOUT cycles (sets sticky nl_err).
module dfr_reservoir_core
    import dfr_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH        = 32,
    parameter int NODE_DATA_WIDTH   = 12,
    parameter int SUM_WIDTH         = 16,
    parameter int NL_TIMEOUT        = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [DATA_WIDTH-1:0]                din,
    input  logic                                 din_valid,
    output logic                                 din_ready,
    input  logic [ETA_W-1:0]                     eta,
    output logic                                 nl_req,
    output logic [SUM_WIDTH-1:0]                 nl_din,
    input  logic                                 nl_ack,
    input  logic [NODE_DATA_WIDTH-1:0]           nl_dout,
    input  logic                                 load_node,
    input  logic [NODE_DATA_WIDTH-1:0]           load_node_din,
    input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_sel,
    output logic [NODE_DATA_WIDTH-1:0]           node_dout,
    output logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_idx,
    output logic                                 frame_done,
    output logic                                 nl_err
);

    localparam int SEL_W = $clog2(NUM_VIRTUAL_NODES);
    localparam int PAD_W = SUM_WIDTH - NODE_DATA_WIDTH;

    if (NUM_VIRTUAL_NODES < 2 || PAD_W < 0 || DATA_WIDTH > 63 || NL_TIMEOUT < 1) begin : g_param_check
        $error("dfr_reservoir_core: unsupported parameter set");
    end

    dfr_state_t                 state_q, state_d;
    logic [SUM_WIDTH-1:0]       sum_q;
    logic [NODE_DATA_WIDTH-1:0] nl_res_q;
    logic [NODE_DATA_WIDTH-1:0] node_last;
    logic [SUM_WIDTH-1:0]       fb_base, fb;
    logic [63:0]                sum_sat;
    logic                       accept, shift_en, load_en, last_node, nl_timeout;

    assign din_ready  = (state_q == IDLE) && en && !load_node;
    assign accept     = din_ready && din_valid;
    assign load_en    = (state_q == IDLE) && load_node;
    assign shift_en   = (state_q == SHIFT);
    assign last_node  = (node_idx == SEL_W'(NUM_VIRTUAL_NODES - 1));
    assign frame_done = shift_en && last_node;
    assign nl_req     = (state_q == NL_WAIT);
    assign nl_din     = sum_q;

    // Oldest node is left-aligned into the sum width before the eta attenuation.
    always_comb begin
        fb_base = SUM_WIDTH'(node_last) << PAD_W;
        fb      = (32'(eta) >= SUM_WIDTH) ? '0 : (fb_base >> eta);
        sum_sat = sat_add(64'(din), 64'(fb), SUM_WIDTH);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SUM;
            SUM:     state_d = NL_WAIT;
            NL_WAIT: if (nl_ack || nl_timeout) state_d = SHIFT;
            SHIFT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            nl_res_q <= '0;
            node_idx <= '0;
        end else begin
            state_q <= state_d;
            if (accept) sum_q <= sum_sat[SUM_WIDTH-1:0];
            if (state_q == NL_WAIT) begin
                if (nl_ack)          nl_res_q <= nl_dout;
                else if (nl_timeout) nl_res_q <= '0;
            end
            if (shift_en) node_idx <= last_node ? '0 : node_idx + 1'b1;
        end
    end

`ifdef DFR_NL_TIMEOUT_EN
    localparam int TO_W = $clog2(NL_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            nl_err_q;

    assign nl_timeout = (state_q == NL_WAIT) && !nl_ack && (to_cnt == TO_W'(NL_TIMEOUT - 1));
    assign nl_err     = nl_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            nl_err_q <= 1'b0;
        end else begin
            to_cnt <= (state_q == NL_WAIT) ? to_cnt + 1'b1 : '0;
            if (nl_timeout) nl_err_q <= 1'b1;
        end
    end
`else
    assign nl_timeout = 1'b0;
    assign nl_err     = 1'b0;
`endif

    reservoir_delay_line #(
        .NUM_VIRTUAL_NODES(NUM_VIRTUAL_NODES),
        .NODE_DATA_WIDTH  (NODE_DATA_WIDTH),
        .SEL_W            (SEL_W)
    ) u_delay_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .shift_din(nl_res_q),
        .load_en  (load_en),
        .load_sel (node_sel),
        .load_din (load_node_din),
        .rd_sel   (node_sel),
        .rd_data  (node_dout),
        .last     (node_last)
    );

endmodule
